// File: rtl/uart_apb_pkg.sv
// rtl/uart_apb_pkg.sv - state encoding and UART register map shared by the APB initiator
package uart_apb_pkg;

  typedef logic [3:0] apb_state_t;

  localparam int ST_IDLE_BIT   = 0;
  localparam int ST_SETUP_BIT  = 1;
  localparam int ST_ACCESS_BIT = 2;
  localparam int ST_RESP_BIT   = 3;

  localparam apb_state_t ST_IDLE   = 4'b0001;
  localparam apb_state_t ST_SETUP  = 4'b0010;
  localparam apb_state_t ST_ACCESS = 4'b0100;
  localparam apb_state_t ST_RESP   = 4'b1000;

  // Byte offsets of the UART register slave this initiator usually drives.
  localparam logic [7:0] UART_REG_DR  = 8'h00;
  localparam logic [7:0] UART_REG_SR  = 8'h04;
  localparam logic [7:0] UART_REG_CR  = 8'h08;
  localparam logic [7:0] UART_REG_IER = 8'h0C;
  localparam logic [7:0] UART_REG_IIR = 8'h10;
  localparam logic [7:0] UART_REG_LCR = 8'h14;
  localparam logic [7:0] UART_REG_BDR = 8'h18;
  localparam logic [7:0] UART_REG_FCR = 8'h1C;
  localparam logic [7:0] UART_REG_LSR = 8'h20;
  localparam logic [7:0] UART_REG_MDR = 8'h24;

  function automatic logic is_word_aligned(input logic [1:0] addr_lsb);
    return addr_lsb == 2'b00;
  endfunction

endpackage

// File: rtl/apb_timeout_cnt.sv
// rtl/apb_timeout_cnt.sv - ACCESS wait-state counter with expiry flag at TIMEOUT_CYCLES-1
module apb_timeout_cnt #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic apb_clk_in,
  input  logic apb_rstn_in,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] r_count;

  // Holds at the last value so a non-power-of-two limit never wraps.
  always_ff @(posedge apb_clk_in or negedge apb_rstn_in) begin
    if (!apb_rstn_in) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && !o_expired) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign o_expired = (r_count == CNT_LAST);

endmodule

// File: rtl/uart_apb_master.sv
// rtl/uart_apb_master.sv - single-beat command to APB3 transfer initiator with timeout
module uart_apb_master
  import uart_apb_pkg::*;
#(
  parameter int APB_DATA_WIDTH = 32,
  parameter int APB_ADDR_WIDTH = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                        apb_clk_in,
  input  logic                        apb_rstn_in,
  input  logic                        cmd_valid_in,
  output logic                        cmd_ready_out,
  input  logic                        cmd_write_in,
  input  logic [APB_ADDR_WIDTH-1:0]   cmd_addr_in,
  input  logic [APB_DATA_WIDTH-1:0]   cmd_wdata_in,
  input  logic [APB_DATA_WIDTH/8-1:0] cmd_strb_in,
  output logic                        rsp_valid_out,
  input  logic                        rsp_ready_in,
  output logic [APB_DATA_WIDTH-1:0]   rsp_rdata_out,
  output logic                        rsp_err_out,
  output logic                        rsp_timeout_out,
  output logic [APB_ADDR_WIDTH-1:0]   apb_addr_out,
  output logic [APB_DATA_WIDTH-1:0]   apb_wdata_out,
  output logic [APB_DATA_WIDTH/8-1:0] apb_strb_out,
  output logic                        apb_write_out,
  output logic                        apb_psel_out,
  output logic                        apb_penable_out,
  input  logic [APB_DATA_WIDTH-1:0]   apb_rdata_in,
  input  logic                        apb_ready_in,
  input  logic                        apb_slverr_in
);

  localparam int STRB_W = APB_DATA_WIDTH / 8;

  apb_state_t                r_state;
  apb_state_t                w_state_nxt;
  logic                      w_accept;
  logic                      w_aligned;
  logic                      w_expired;
  logic                      w_cnt_clear;
  logic                      w_cnt_enable;
  logic                      w_psel_nxt;
  logic                      w_penable_nxt;
  logic                      r_psel;
  logic                      r_penable;
  logic [APB_ADDR_WIDTH-1:0] r_apb_addr;
  logic [APB_DATA_WIDTH-1:0] r_apb_wdata;
  logic [STRB_W-1:0]         r_apb_strb;
  logic                      r_apb_write;
  logic [APB_DATA_WIDTH-1:0] r_rsp_rdata;
  logic                      r_rsp_err;
  logic                      r_rsp_timeout;

  assign w_accept  = r_state[ST_IDLE_BIT] & cmd_valid_in;
  assign w_aligned = is_word_aligned(cmd_addr_in[1:0]);

  always_ff @(posedge apb_clk_in or negedge apb_rstn_in) begin
    if (!apb_rstn_in) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (cmd_valid_in) w_state_nxt = w_aligned ? ST_SETUP : ST_RESP;
      ST_SETUP:  w_state_nxt = ST_ACCESS;
      ST_ACCESS: if (apb_ready_in || w_expired) w_state_nxt = ST_RESP;
      ST_RESP:   if (rsp_ready_in) w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // psel/penable come from the next state so they leave flops, not state decode.
  always_comb begin
    w_psel_nxt    = (w_state_nxt == ST_SETUP) || (w_state_nxt == ST_ACCESS);
    w_penable_nxt = (w_state_nxt == ST_ACCESS);
    w_cnt_clear   = r_state[ST_SETUP_BIT];
    w_cnt_enable  = r_state[ST_ACCESS_BIT] & ~apb_ready_in;
  end

  always_ff @(posedge apb_clk_in or negedge apb_rstn_in) begin
    if (!apb_rstn_in) begin
      r_psel    <= 1'b0;
      r_penable <= 1'b0;
    end else begin
      r_psel    <= w_psel_nxt;
      r_penable <= w_penable_nxt;
    end
  end

  apb_timeout_cnt #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timeout_cnt (
    .apb_clk_in  (apb_clk_in),
    .apb_rstn_in (apb_rstn_in),
    .i_clear     (w_cnt_clear),
    .i_enable    (w_cnt_enable),
    .o_expired   (w_expired)
  );

  always_ff @(posedge apb_clk_in or negedge apb_rstn_in) begin
    if (!apb_rstn_in) begin
      r_apb_addr  <= '0;
      r_apb_wdata <= '0;
      r_apb_strb  <= '0;
      r_apb_write <= 1'b0;
    end else if (w_accept) begin
      r_apb_addr  <= cmd_addr_in;
      r_apb_wdata <= cmd_wdata_in;
      r_apb_strb  <= cmd_write_in ? cmd_strb_in : '0;
      r_apb_write <= cmd_write_in;
    end
  end

  // Ready has priority over expiry when both land on the same edge.
  always_ff @(posedge apb_clk_in or negedge apb_rstn_in) begin
    if (!apb_rstn_in) begin
      r_rsp_rdata   <= '0;
      r_rsp_err     <= 1'b0;
      r_rsp_timeout <= 1'b0;
    end else if (w_accept && !w_aligned) begin
      r_rsp_rdata   <= '0;
      r_rsp_err     <= 1'b1;
      r_rsp_timeout <= 1'b0;
    end else if (r_state[ST_ACCESS_BIT] && apb_ready_in) begin
      r_rsp_rdata   <= r_apb_write ? '0 : apb_rdata_in;
      r_rsp_err     <= apb_slverr_in;
      r_rsp_timeout <= 1'b0;
    end else if (r_state[ST_ACCESS_BIT] && w_expired) begin
      r_rsp_rdata   <= '0;
      r_rsp_err     <= 1'b1;
      r_rsp_timeout <= 1'b1;
    end else if (r_state[ST_RESP_BIT] && rsp_ready_in) begin
      r_rsp_rdata   <= '0;
      r_rsp_err     <= 1'b0;
      r_rsp_timeout <= 1'b0;
    end
  end

  assign cmd_ready_out   = r_state[ST_IDLE_BIT];
  assign rsp_valid_out   = r_state[ST_RESP_BIT];
  assign rsp_rdata_out   = r_rsp_rdata;
  assign rsp_err_out     = r_rsp_err;
  assign rsp_timeout_out = r_rsp_timeout;
  assign apb_addr_out    = r_apb_addr;
  assign apb_wdata_out   = r_apb_wdata;
  assign apb_strb_out    = r_apb_strb;
  assign apb_write_out   = r_apb_write;
  assign apb_psel_out    = r_psel;
  assign apb_penable_out = r_penable;

endmodule

// File: tb/tb_uart_apb_master.sv
// tb/tb_uart_apb_master.sv - self-checking bench for uart_apb_master
module tb_uart_apb_master;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int SW = DW / 8;
  localparam int T  = 16;

  logic          apb_clk_in = 1'b0;
  logic          apb_rstn_in = 1'b0;
  logic          cmd_valid_in = 1'b0;
  logic          cmd_ready_out;
  logic          cmd_write_in = 1'b0;
  logic [AW-1:0] cmd_addr_in = '0;
  logic [DW-1:0] cmd_wdata_in = '0;
  logic [SW-1:0] cmd_strb_in = '0;
  logic          rsp_valid_out;
  logic          rsp_ready_in = 1'b0;
  logic [DW-1:0] rsp_rdata_out;
  logic          rsp_err_out;
  logic          rsp_timeout_out;
  logic [AW-1:0] apb_addr_out;
  logic [DW-1:0] apb_wdata_out;
  logic [SW-1:0] apb_strb_out;
  logic          apb_write_out;
  logic          apb_psel_out;
  logic          apb_penable_out;
  logic [DW-1:0] apb_rdata_in = '0;
  logic          apb_ready_in = 1'b0;
  logic          apb_slverr_in = 1'b0;

  always #5 apb_clk_in = ~apb_clk_in;

  uart_apb_master #(
    .APB_DATA_WIDTH (DW),
    .APB_ADDR_WIDTH (AW),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .apb_clk_in      (apb_clk_in),
    .apb_rstn_in     (apb_rstn_in),
    .cmd_valid_in    (cmd_valid_in),
    .cmd_ready_out   (cmd_ready_out),
    .cmd_write_in    (cmd_write_in),
    .cmd_addr_in     (cmd_addr_in),
    .cmd_wdata_in    (cmd_wdata_in),
    .cmd_strb_in     (cmd_strb_in),
    .rsp_valid_out   (rsp_valid_out),
    .rsp_ready_in    (rsp_ready_in),
    .rsp_rdata_out   (rsp_rdata_out),
    .rsp_err_out     (rsp_err_out),
    .rsp_timeout_out (rsp_timeout_out),
    .apb_addr_out    (apb_addr_out),
    .apb_wdata_out   (apb_wdata_out),
    .apb_strb_out    (apb_strb_out),
    .apb_write_out   (apb_write_out),
    .apb_psel_out    (apb_psel_out),
    .apb_penable_out (apb_penable_out),
    .apb_rdata_in    (apb_rdata_in),
    .apb_ready_in    (apb_ready_in),
    .apb_slverr_in   (apb_slverr_in)
  );

  // waits >= T models a slave that never raises ready.
  typedef struct {
    logic          wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] strb;
    int            waits;
    logic          slverr;
    logic [DW-1:0] srdata;
    int            hold;
    logic          exp_err;
    logic          exp_to;
    logic [DW-1:0] exp_rdata;
    int            exp_lat;
    int            exp_acc;
  } vec_t;

  int   checks = 0;
  int   failures = 0;
  vec_t tbl[8];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Latency counts edges after the accept edge until rsp_valid is visible.
  function automatic vec_t model(input vec_t v);
    vec_t r = v;
    if (v.addr[1:0] != 2'b00) begin
      r.exp_err = 1'b1; r.exp_to = 1'b0; r.exp_rdata = '0; r.exp_lat = 0; r.exp_acc = 0;
    end else if (v.waits >= T) begin
      r.exp_err = 1'b1; r.exp_to = 1'b1; r.exp_rdata = '0; r.exp_lat = T + 1; r.exp_acc = T;
    end else begin
      r.exp_err = v.slverr; r.exp_to = 1'b0;
      r.exp_rdata = v.wr ? '0 : v.srdata;
      r.exp_lat = 2 + v.waits; r.exp_acc = v.waits + 1;
    end
    return r;
  endfunction

  // Entered and left #1 after a rising edge with cmd_ready expected high.
  task automatic run_txn(input vec_t v, input string tag);
    int            n;
    int            acc;
    logic          seen;
    logic          bad;
    logic          hold_bad;
    logic [DW-1:0] r0;
    logic          e0;
    logic          t0;
    cmd_valid_in = 1'b1;
    cmd_write_in = v.wr;
    cmd_addr_in  = v.addr;
    cmd_wdata_in = v.wdata;
    cmd_strb_in  = v.strb;
    @(posedge apb_clk_in); #1;
    cmd_valid_in = 1'b0;
    cmd_addr_in  = $urandom;
    cmd_wdata_in = $urandom;
    cmd_strb_in  = SW'($urandom);
    n = 0; acc = 0; seen = 1'b0; bad = 1'b0;
    while (!rsp_valid_out && n < 60) begin
      if (cmd_ready_out) bad = 1'b1;
      if (apb_psel_out) begin
        if (apb_addr_out !== v.addr || apb_write_out !== v.wr || apb_wdata_out !== v.wdata ||
            apb_strb_out !== (v.wr ? v.strb : SW'(0))) bad = 1'b1;
        if (!seen && apb_penable_out) bad = 1'b1;
        seen = 1'b1;
      end else if (apb_penable_out) begin
        bad = 1'b1;
      end
      if (apb_psel_out && apb_penable_out && acc == v.waits) begin
        apb_ready_in = 1'b1; apb_slverr_in = v.slverr; apb_rdata_in = v.srdata;
      end else begin
        apb_ready_in = 1'b0; apb_slverr_in = 1'($urandom); apb_rdata_in = $urandom;
      end
      if (apb_psel_out && apb_penable_out) acc++;
      @(posedge apb_clk_in); #1;
      n++;
    end
    apb_ready_in = 1'b0;
    apb_slverr_in = 1'b0;
    chk({tag, "_lat"}, 64'(n), 64'(v.exp_lat));
    chk({tag, "_err"}, 64'(rsp_err_out), 64'(v.exp_err));
    chk({tag, "_timeout"}, 64'(rsp_timeout_out), 64'(v.exp_to));
    chk({tag, "_rdata"}, 64'(rsp_rdata_out), 64'(v.exp_rdata));
    chk({tag, "_access_cycles"}, 64'(acc), 64'(v.exp_acc));
    chk({tag, "_bus_protocol"}, 64'(bad), 64'(0));
    r0 = rsp_rdata_out; e0 = rsp_err_out; t0 = rsp_timeout_out; hold_bad = 1'b0;
    for (int h = 0; h < v.hold; h++) begin
      @(posedge apb_clk_in); #1;
      if (!rsp_valid_out || rsp_rdata_out !== r0 || rsp_err_out !== e0 ||
          rsp_timeout_out !== t0 || apb_psel_out || cmd_ready_out) hold_bad = 1'b1;
    end
    chk({tag, "_rsp_hold"}, 64'(hold_bad), 64'(0));
    rsp_ready_in = 1'b1;
    @(posedge apb_clk_in); #1;
    rsp_ready_in = 1'b0;
    chk({tag, "_ready_after_hs"}, 64'({cmd_ready_out, rsp_valid_out}), 64'(2'b10));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    vec_t v;
    int   n;
    tbl[0] = '{1'b1, 32'h04, 32'h0000_0F00, 4'hF, 0,  1'b0, 32'h0,         1, 1'b0, 1'b0, 32'h0,         2,  1};
    tbl[1] = '{1'b0, 32'h18, 32'h1234_5678, 4'hF, 3,  1'b0, 32'h1102_0002, 4, 1'b0, 1'b0, 32'h1102_0002, 5,  4};
    tbl[2] = '{1'b0, 32'h08, 32'h0,         4'h3, 16, 1'b0, 32'hCAFE_F00D, 0, 1'b1, 1'b1, 32'h0,         17, 16};
    tbl[3] = '{1'b0, 32'h30, 32'h0,         4'hF, 1,  1'b1, 32'hA5A5_0001, 0, 1'b1, 1'b0, 32'hA5A5_0001, 3,  2};
    tbl[4] = '{1'b1, 32'h06, 32'h55,        4'hF, 0,  1'b0, 32'h0,         2, 1'b1, 1'b0, 32'h0,         0,  0};
    tbl[5] = '{1'b1, 32'h24, 32'hDEAD_BEEF, 4'h5, 15, 1'b0, 32'hFFFF,      1, 1'b0, 1'b0, 32'h0,         17, 16};
    tbl[6] = '{1'b0, 32'h01, 32'h0,         4'hF, 0,  1'b0, 32'h1234,      0, 1'b1, 1'b0, 32'h0,         0,  0};
    tbl[7] = '{1'b1, 32'h10, 32'h0BAD_F00D, 4'h9, 2,  1'b1, 32'h77,        0, 1'b1, 1'b0, 32'h0,         4,  3};

    repeat (3) @(posedge apb_clk_in);
    #1;
    chk("reset_handshake", 64'({cmd_ready_out, rsp_valid_out}), 64'(2'b10));
    chk("reset_bus", 64'({apb_psel_out, apb_penable_out, apb_write_out, apb_strb_out}), 64'(0));
    chk("reset_addr_wdata", 64'({apb_addr_out, apb_wdata_out}), 64'(0));
    chk("reset_rsp", 64'({rsp_err_out, rsp_timeout_out, rsp_rdata_out}), 64'(0));
    #2 apb_rstn_in = 1'b1;
    @(posedge apb_clk_in); #1;

    for (int i = 0; i < 8; i++) run_txn(tbl[i], $sformatf("tbl%0d", i));

    for (int i = 0; i < 40; i++) begin
      v.wr     = 1'($urandom_range(0, 1));
      v.addr   = $urandom;
      if ($urandom_range(0, 3) != 0) v.addr[1:0] = 2'b00;
      v.wdata  = $urandom;
      v.strb   = SW'($urandom);
      v.waits  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(12, 20)) : int'($urandom_range(0, 3));
      v.slverr = ($urandom_range(0, 3) == 0);
      v.srdata = $urandom;
      v.hold   = int'($urandom_range(0, 3));
      run_txn(model(v), $sformatf("rnd%0d", i));
    end

    // Reset asserted mid-ACCESS against a slave that never answers.
    cmd_valid_in = 1'b1; cmd_write_in = 1'b0; cmd_addr_in = 32'h0C; cmd_strb_in = '0;
    @(posedge apb_clk_in); #1;
    cmd_valid_in = 1'b0;
    apb_ready_in = 1'b0;
    n = 0;
    while (!(apb_psel_out && apb_penable_out) && n < 10) begin
      @(posedge apb_clk_in); #1;
      n++;
    end
    chk("rst_reached_access", 64'(apb_psel_out && apb_penable_out), 64'(1));
    @(posedge apb_clk_in); #3;
    apb_rstn_in = 1'b0;
    #1;
    chk("rst_async_bus", 64'({apb_psel_out, apb_penable_out, rsp_valid_out}), 64'(0));
    chk("rst_async_ready", 64'(cmd_ready_out), 64'(1));
    @(posedge apb_clk_in); #3;
    apb_rstn_in = 1'b1;
    @(posedge apb_clk_in); #1;
    chk("rst_release", 64'({cmd_ready_out, rsp_valid_out, apb_psel_out}), 64'(3'b100));
    v = '{1'b1, 32'h0C, 32'h0000_00C3, 4'h1, 1, 1'b0, 32'h0, 1, 1'b0, 1'b0, 32'h0, 3, 2};
    run_txn(v, "post_rst");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_apb_master.md
# uart_apb_master

APB initiator that turns single-beat register commands into APB3 read/write transfers. It drives the UART register slave and the peripheral bus from a test sequencer or a small controller. It accepts one command at a time over a valid/ready port, runs the SETUP/ACCESS protocol with wait-state support and a bounded timeout, and returns each result over a valid/ready response port.

## Interface
- APB_DATA_WIDTH, 32, data bus width (multiple of 8)
- APB_ADDR_WIDTH, 32, address bus width
- TIMEOUT_CYCLES, 16, maximum ACCESS cycles before abort (≥2)

Clock and reset: reset apb_rstn_in, asynchronous, active-low; clock apb_clk_in.

- apb_clk_in  in  1  clock
- apb_rstn_in  in  1  async active-low reset
- cmd_valid_in  in  1  command present
- cmd_ready_out  out  1  command accepted when high with valid
- cmd_write_in  in  1  1=write, 0=read
- cmd_addr_in  in  APB_ADDR_WIDTH  byte address
- cmd_wdata_in  in  APB_DATA_WIDTH  write data
- cmd_strb_in  in  APB_DATA_WIDTH/8  write byte strobes
- rsp_valid_out  out  1  response present
- rsp_ready_in  in  1  response consumed
- rsp_rdata_out  out  APB_DATA_WIDTH  read data (0 for writes/errors)
- rsp_err_out  out  1  slave error, timeout or misalignment
- rsp_timeout_out  out  1  error cause was timeout
- apb_addr_out, apb_wdata_out, apb_strb_out, apb_write_out  out  widths as above  APB request fields
- apb_psel_out, apb_penable_out  out  1  APB select/enable
- apb_rdata_in  in  APB_DATA_WIDTH  read data
- apb_ready_in, apb_slverr_in  in  1  PREADY/PSLVERR

## Operation
- States: IDLE, SETUP, ACCESS, RESP.
- IDLE: cmd_ready_out=1. On cmd_valid_in, register the write, address, wdata and strb fields into the apb_* outputs.
  - Address aligned (addr[1:0]=0): go to SETUP.
  - Address misaligned: go straight to RESP with err=1, rdata=0, timeout=0. No bus cycle is issued.
- SETUP: psel=1, penable=0. Always goes to ACCESS.
- ACCESS: psel=1, penable=1. The wait counter increments on each edge where apb_ready_in=0.
  - apb_ready_in=1: go to RESP. rdata = apb_rdata_in for reads, 0 for writes. err = apb_slverr_in.
  - Counter = TIMEOUT_CYCLES-1 with ready=0: abort. Go to RESP with err=1, timeout=1, rdata=0.
  - Ready and timeout on the same edge: ready wins.
- RESP: psel=0, penable=0, rsp_valid_out=1. Response fields are held stable until rsp_ready_in, then go to IDLE.
- apb_addr/write/wdata/strb are held constant from SETUP through ACCESS. They keep their value until the next accept.
- apb_strb_out is forced to 0 for reads.
- Reset values: all outputs 0 except cmd_ready_out=1; state IDLE; counter 0.
- Reset mid-transfer: psel/penable drop immediately (asynchronously). Any in-flight command or pending response is discarded.

## Timing
- All outputs are registered. cmd_ready_out is decoded from the state register.
- Command accepted at edge E0 → SETUP after E0. ACCESS after E1. Zero-wait completion sampled at E2. rsp_valid_out high after E2.
- Each wait state adds one cycle. A timeout response appears after edge E1+TIMEOUT_CYCLES.
- Response consumed at edge En → cmd_ready_out=1 after En. Minimum command-to-command period is 4 cycles.
- Misaligned command: rsp_valid_out is high one cycle after accept.

## Structure
- Package uart_apb_pkg: state encoding (one-hot, 4 bits), localparams ST_IDLE/ST_SETUP/ST_ACCESS/ST_RESP, register offset constants shared with the UART register slave (DR=0x00 … MDR=0x24).
- Sub-module apb_timeout_cnt: width $clog2(TIMEOUT_CYCLES). Clear on SETUP, increment while enabled, expired flag at TIMEOUT_CYCLES-1.

## Test plan
- Write addr 0x04, wdata 0x0000_0F00, strb 0xF, zero-wait slave → psel at E1, penable at E2, rsp after E2 with err=0, rdata=0.
- Read addr 0x18, slave returns 0x1102_0002 after 3 wait states → rsp_rdata_out=0x1102_0002 at E5, err=0, rsp held while rsp_ready_in=0 for 4 cycles.
- Slave never asserts ready, TIMEOUT_CYCLES=16 → psel drops after 16 ACCESS cycles, rsp err=1 timeout=1 rdata=0.
- Slave returns ready with slverr=1 on a read of 0x30 → err=1, timeout=0, rdata captured; next command accepted one cycle after the rsp handshake.
- Misaligned address 0x06 → no psel ever, rsp valid one cycle after accept, err=1.
- Assert apb_rstn_in low during ACCESS → psel/penable/rsp_valid 0 immediately; after release cmd_ready_out=1 and a fresh write completes normally.
